// File: rtl/rle_sprite_decoder.sv
// rle_sprite_decoder: raster-order RLE sprite fetch with integer upscale
// and per-frame ROM base; pixel index/subpixel registered one clock late.
module rle_sprite_decoder #(
  parameter int         SPR_W      = 32,
  parameter int         SPR_H      = 32,
  parameter int         SCALE_LOG2 = 1,
  parameter int         ADDR_W     = 10,
  parameter logic [2:0] BG_INDEX   = 3'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              display_on,
  input  logic              frame_start,
  input  logic [9:0]        spr_x,
  input  logic [9:0]        spr_y,
  input  logic [ADDR_W-1:0] frame_base,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [2:0]        index,
  output logic [1:0]        subpixel,
  output logic              in_sprite
);

  localparam int SCALE = 1 << SCALE_LOG2;
  localparam int SW    = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int CW    = (SPR_W > 1) ? $clog2(SPR_W) : 1;

  localparam logic [10:0]   WIN_W    = 11'(SPR_W * SCALE);
  localparam logic [10:0]   WIN_H    = 11'(SPR_H * SCALE);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);

  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [ADDR_W-1:0] row_ptr, row_ptr_n;
  logic [4:0]        run_rem, run_rem_n;
  logic [2:0]        cur_idx, cur_idx_n;
  logic [SW-1:0]     sub_cnt, sub_n;
  logic [SW-1:0]     rep, rep_n;
  logic [CW-1:0]     col, col_n;

  logic       hit_x, hit_y, hit;
  logic       sub_last, src_start;
  logic       fetch, run_step, row_end;
  logic [2:0] pix_idx;

  assign hit_x = ({1'b0, hpos} >= {1'b0, spr_x}) &&
                 ({1'b0, hpos} <  {1'b0, spr_x} + WIN_W);
  assign hit_y = ({1'b0, vpos} >= {1'b0, spr_y}) &&
                 ({1'b0, vpos} <  {1'b0, spr_y} + WIN_H);
  assign hit   = hit_x && hit_y;

  assign sub_last  = (sub_cnt == SUB_LAST);
  assign src_start = hit && (sub_cnt == '0);
  assign fetch     = src_start && (run_rem == '0);
  assign run_step  = src_start && (run_rem != '0);
  assign row_end   = hit && sub_last && (col == COL_LAST);

  // A fetching pixel takes its colour straight from the ROM byte.
  assign pix_idx  = fetch ? rom_data[7:5] : cur_idx;
  assign rom_addr = ptr;

  always_comb begin
    ptr_n     = ptr;
    row_ptr_n = row_ptr;
    run_rem_n = run_rem;
    cur_idx_n = cur_idx;
    sub_n     = sub_cnt;
    col_n     = col;
    rep_n     = rep;
    if (hit) begin
      sub_n = sub_last ? '0 : sub_cnt + 1'b1;
      if (sub_last) col_n = col + 1'b1;
      unique case (1'b1)
        fetch: begin
          cur_idx_n = rom_data[7:5];
          run_rem_n = rom_data[4:0];
          ptr_n     = ptr + 1'b1;
        end
        run_step: run_rem_n = run_rem - 1'b1;
        default: ;
      endcase
      // Leftover run length past the row edge is dropped.
      if (row_end) begin
        run_rem_n = '0;
        col_n     = '0;
        sub_n     = '0;
        if (rep == SUB_LAST) begin
          row_ptr_n = ptr_n;
          rep_n     = '0;
        end else begin
          ptr_n = row_ptr;
          rep_n = rep + 1'b1;
        end
      end
    end
    if (frame_start) begin
      ptr_n     = frame_base;
      row_ptr_n = frame_base;
      run_rem_n = '0;
      rep_n     = '0;
      col_n     = '0;
      sub_n     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      row_ptr <= '0;
      run_rem <= '0;
      cur_idx <= '0;
      sub_cnt <= '0;
      col     <= '0;
      rep     <= '0;
    end else begin
      ptr     <= ptr_n;
      row_ptr <= row_ptr_n;
      run_rem <= run_rem_n;
      cur_idx <= cur_idx_n;
      sub_cnt <= sub_n;
      col     <= col_n;
      rep     <= rep_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index     <= BG_INDEX;
      subpixel  <= '0;
      in_sprite <= 1'b0;
    end else begin
      index     <= (hit && display_on) ? pix_idx : BG_INDEX;
      subpixel  <= {vpos[0], hpos[0]};
      in_sprite <= hit && display_on;
    end
  end

endmodule

// File: tb/tb_rle_sprite_decoder.sv
// tb_rle_sprite_decoder: directed scenes with a queued expected-output
// scoreboard fed by a source-row decode model of the ROM.
module tb_rle_sprite_decoder;

  localparam int AW  = 10;
  localparam int SWD = 32;
  localparam int SH  = 32;
  localparam int S   = 1;
  localparam int SC  = 2;
  localparam int BG  = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    hpos, vpos, spr_x, spr_y;
  logic          display_on, frame_start;
  logic [AW-1:0] frame_base, rom_addr;
  logic [7:0]    rom_data;
  logic [2:0]    index;
  logic [1:0]    subpixel;
  logic          in_sprite;

  logic [7:0] rom [0:1023];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  rle_sprite_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .frame_start(frame_start),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .frame_base (frame_base),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .index      (index),
    .subpixel   (subpixel),
    .in_sprite  (in_sprite)
  );

  typedef struct packed {
    logic [2:0]    idx;
    logic          ins;
    logic [1:0]    sub;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;

  logic [2:0]    row_idx  [SWD];
  logic [AW-1:0] row_addr [SWD];
  logic [AW-1:0] maddr, mnext;
  int            mrep;

  task automatic chk(input string tag, input int h, input int v,
                     input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s h=%0d v=%0d got=%0h want=%0h",
             tag, h, v, got, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_index"}, 0, 0, 16'(index), 16'(BG));
    chk({tag, "_sub"}, 0, 0, 16'(subpixel), 16'd0);
    chk({tag, "_ins"}, 0, 0, 16'(in_sprite), 16'd0);
    chk({tag, "_addr"}, 0, 0, 16'(rom_addr), 16'd0);
  endtask

  // Expand one source row: colour per column and ROM pointer after it.
  task automatic decode(input logic [AW-1:0] a);
    int c;
    logic [AW-1:0] p;
    c = 0;
    p = a;
    while (c < SWD) begin
      int n;
      logic [2:0] ix;
      n  = int'(rom[p][4:0]) + 1;
      ix = rom[p][7:5];
      p  = p + 1'b1;
      for (int k = 0; k < n && c < SWD; k++) begin
        row_idx[c]  = ix;
        row_addr[c] = p;
        c++;
      end
    end
    mnext = p;
  endtask

  task automatic step(input int h, input int v, input logic don,
                      input logic fs, input exp_t e);
    exp_t g;
    hpos        = 10'(h);
    vpos        = 10'(v);
    display_on  = don;
    frame_start = fs;
    sb.push_back(e);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    g = sb.pop_front();
    chk("index", h, v, 16'(index), 16'(g.idx));
    chk("in_sprite", h, v, 16'(in_sprite), 16'(g.ins));
    chk("subpixel", h, v, 16'(subpixel), 16'(g.sub));
    chk("rom_addr", h, v, 16'(rom_addr), 16'(g.addr));
  endtask

  task automatic fstart(input logic [AW-1:0] fb);
    exp_t e;
    frame_base = fb;
    e.idx  = 3'(BG);
    e.ins  = 1'b0;
    e.sub  = 2'b00;
    e.addr = fb;
    step(0, 500, 1'b1, 1'b1, e);
    maddr = fb;
    mrep  = 0;
  endtask

  task automatic line(input int v, input logic don,
                      input int h0, input int h1);
    bit win;
    int xe;
    logic [AW-1:0] nadr;
    exp_t e;
    xe   = int'(spr_x) + SWD * SC;
    win  = v >= int'(spr_y) && v < int'(spr_y) + SH * SC;
    nadr = maddr;
    if (win) begin
      decode(maddr);
      if (mrep == SC - 1) nadr = mnext;
    end
    for (int h = h0; h <= h1; h++) begin
      bit hx;
      int c;
      hx = win && h >= int'(spr_x) && h < xe;
      c  = hx ? (h - int'(spr_x)) >> S : 0;
      e.idx = (hx && don) ? row_idx[c] : 3'(BG);
      e.ins = hx && don;
      e.sub = {v[0], h[0]};
      if (!win || h < int'(spr_x)) e.addr = maddr;
      else if (h < xe - 1)         e.addr = row_addr[c];
      else                         e.addr = nadr;
      step(h, v, don, 1'b0, e);
    end
    if (win && h1 >= xe - 1) begin
      maddr = nadr;
      mrep  = (mrep == SC - 1) ? 0 : mrep + 1;
    end
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 1024; i++) rom[i] = 8'h1F;
    rom[10'h040] = 8'hFF;
    rom[10'h041] = 8'hBF;
    reset       = 1'b1;
    hpos        = '0;
    vpos        = '0;
    display_on  = 1'b0;
    frame_start = 1'b0;
    spr_x       = 10'd100;
    spr_y       = 10'd50;
    frame_base  = '0;
    maddr       = '0;
    mnext       = '0;
    mrep        = 0;

    #1;
    chk_zero("por");
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_zero("por_hold");
    end
    reset = 1'b0;

    // Get the decoder mid-run, then reset without a clock edge.
    fstart(10'h040);
    line(50, 1'b1, 96, 110);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("async");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_zero("async_hold");
    end
    reset = 1'b0;

    // Single long run plus vertical replay.
    fstart(10'h040);
    line(50, 1'b1, 96, 170);
    line(51, 1'b1, 96, 170);
    line(52, 1'b1, 96, 170);

    // Run crossing the row edge gets truncated.
    rom[10'h040] = 8'h2F;
    rom[10'h041] = 8'hDF;
    rom[10'h042] = 8'h5F;
    fstart(10'h040);
    line(50, 1'b1, 96, 170);
    line(51, 1'b1, 96, 170);
    line(52, 1'b1, 96, 170);

    // Blanked line still walks the ROM.
    fstart(10'h040);
    line(50, 1'b0, 96, 170);
    line(51, 1'b1, 96, 170);
    line(52, 1'b0, 96, 170);

    // frame_start landing on a fetch cycle mid-sprite.
    rom[10'h080] = 8'h29;
    rom[10'h081] = 8'h49;
    rom[10'h082] = 8'h69;
    rom[10'h083] = 8'h89;
    rom[10'h100] = 8'hE3;
    fstart(10'h080);
    line(60, 1'b1, 96, 119);
    frame_base = 10'h100;
    e.idx  = 3'd2;
    e.ins  = 1'b1;
    e.sub  = 2'b00;
    e.addr = 10'h100;
    step(120, 60, 1'b1, 1'b1, e);
    e.idx  = 3'd7;
    e.sub  = 2'b01;
    e.addr = 10'h101;
    step(121, 60, 1'b1, 1'b0, e);
    e.sub  = 2'b00;
    step(122, 60, 1'b1, 1'b0, e);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
